// File: rtl/max_int32_serial_if.sv
// Operand/result handshake bundle for the bit-serial signed max unit.
// The slave modport is the compute block; the master modport is its producer/consumer.
interface max_int32_serial_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             gt;
    logic             busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Y, gt, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Y, gt, busy
    );
endinterface

// File: rtl/max_int32_serial.sv
// Bit-serial signed max: resolves A > B one bit per cycle, MSB first, then
// presents max(A,B) and the A>B flag until the consumer accepts.
module max_int32_serial #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    max_int32_serial_if.slave   bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             gt_q, gt_d;
    logic             decided_q, decided_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic bit_a_s;
    logic bit_b_s;
    logic hit_s;
    logic finish_s;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            y_q       <= {WIDTH{1'b0}};
            gt_q      <= 1'b0;
            decided_q <= 1'b0;
            idx_q     <= IDX_MSB;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            y_q       <= y_d;
            gt_q      <= gt_d;
            decided_q <= decided_d;
            idx_q     <= idx_d;
        end
    end

    // Next-state and per-bit compare decision
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        y_d       = y_q;
        gt_d      = gt_q;
        decided_d = decided_q;
        idx_d     = idx_q;
        bit_a_s   = a_q[idx_q];
        bit_b_s   = b_q[idx_q];
        hit_s     = 1'b0;
        finish_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d       = bus.A;
                    b_d       = bus.B;
                    idx_d     = IDX_MSB;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    state_d   = S_CMP;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_CMP: begin
                hit_s = !decided_q && (bit_a_s != bit_b_s);
                // A differing sign bit means the operand with sign 0 is larger
                if (hit_s) begin
                    gt_d      = (idx_q == IDX_MSB) ? bit_b_s : bit_a_s;
                    decided_d = 1'b1;
                end else begin
                    gt_d      = gt_q;
                    decided_d = decided_q;
                end
                finish_s = (idx_q == IDX_ZERO) || (EARLY_EXIT && hit_s);
                if (finish_s) begin
                    y_d     = gt_d ? a_q : b_q;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q - IDX_ONE;
                    state_d = S_CMP;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.Y         = y_q;
    assign bus.gt        = gt_q;

endmodule

// File: tb/tb_max_int32_serial.sv
// Directed bench for max_int32_serial: one instance with full-length compare,
// one with early exit, checked with immediate assertions.
module tb_max_int32_serial;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    max_int32_serial_if #(.WIDTH(32)) if0 ();
    max_int32_serial_if #(.WIDTH(32)) if1 ();

    max_int32_serial #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    max_int32_serial #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] f_y(input int sel);
        return (sel == 0) ? if0.Y : if1.Y;
    endfunction
    function automatic logic f_gt(input int sel);
        return (sel == 0) ? if0.gt : if1.gt;
    endfunction
    function automatic logic f_ov(input int sel);
        return (sel == 0) ? if0.out_valid : if1.out_valid;
    endfunction
    function automatic logic f_ir(input int sel);
        return (sel == 0) ? if0.in_ready : if1.in_ready;
    endfunction
    function automatic logic f_busy(input int sel);
        return (sel == 0) ? if0.busy : if1.busy;
    endfunction

    task automatic drive_in(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (sel == 0) begin
            if0.in_valid = v; if0.A = a; if0.B = b;
        end else begin
            if1.in_valid = v; if1.A = a; if1.B = b;
        end
    endtask

    task automatic drive_rdy(input int sel, input logic r);
        if (sel == 0) if0.out_ready = r;
        else          if1.out_ready = r;
    endtask

    task automatic start_op(input int sel, input logic [31:0] a, input logic [31:0] b, input string tag);
        chk({tag, "_in_ready_pre"}, {31'd0, f_ir(sel)}, 32'd1);
        drive_in(sel, 1'b1, a, b);
        @(posedge clk); #1;
        // scramble operands after accept: result must not depend on them
        drive_in(sel, 1'b0, ~a, ~b);
        chk({tag, "_in_ready_busy"}, {31'd0, f_ir(sel)}, 32'd0);
        chk({tag, "_busy"}, {31'd0, f_busy(sel)}, 32'd1);
    endtask

    task automatic wait_result(input int sel, input int exp_lat, input logic [31:0] exp_y,
                               input logic exp_gt, input string tag);
        int cyc;
        cyc = 0;
        while (!f_ov(sel) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_Y"}, f_y(sel), exp_y);
        chk({tag, "_gt"}, {31'd0, f_gt(sel)}, {31'd0, exp_gt});
    endtask

    task automatic finish_op(input int sel, input string tag);
        drive_rdy(sel, 1'b1);
        @(posedge clk); #1;
        drive_rdy(sel, 1'b0);
        chk({tag, "_ov_after"}, {31'd0, f_ov(sel)}, 32'd0);
        chk({tag, "_in_ready_after"}, {31'd0, f_ir(sel)}, 32'd1);
    endtask

    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [31:0] y, input logic g, input string tag);
        start_op(sel, a, b, tag);
        wait_result(sel, lat, y, g, tag);
        finish_op(sel, tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive_in(0, 1'b0, 32'd0, 32'd0);
        drive_in(1, 1'b0, 32'd0, 32'd0);
        drive_rdy(0, 1'b0);
        drive_rdy(1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov", {31'd0, if0.out_valid}, 32'd0);
        chk("rst_Y", if0.Y, 32'd0);
        chk("rst_gt", {31'd0, if0.gt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'd0, if0.in_ready}, 32'd1);
        chk("rst_busy", {31'd0, if0.busy}, 32'd0);

        run_op(0, 32'h0000_0005, 32'hFFFF_FFFD, 32, 32'h0000_0005, 1'b1, "pos_vs_neg");
        run_op(0, 32'hFFFF_FFFF, 32'h8000_0000, 32, 32'hFFFF_FFFF, 1'b1, "m1_vs_min");
        run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFF, 1'b0, "min_vs_m1");
        run_op(1, 32'h1234_5678, 32'h1234_5678, 32, 32'h1234_5678, 1'b0, "ee_tie");
        run_op(1, 32'h7FFF_FFFF, 32'h8000_0000, 1,  32'h7FFF_FFFF, 1'b1, "ee_sign");
        run_op(1, 32'h0000_0010, 32'h0000_0018, 29, 32'h0000_0018, 1'b0, "ee_bit3");

        // backpressure: result held, new operands refused
        start_op(0, 32'h0000_0100, 32'h0000_0200, "bp");
        wait_result(0, 32, 32'h0000_0200, 1'b0, "bp");
        drive_in(0, 1'b1, 32'h7000_0000, 32'h0000_0001);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_Y", if0.Y, 32'h0000_0200);
            chk("bp_hold_gt", {31'd0, if0.gt}, 32'd0);
            chk("bp_hold_ov", {31'd0, if0.out_valid}, 32'd1);
            chk("bp_hold_in_ready", {31'd0, if0.in_ready}, 32'd0);
        end
        drive_in(0, 1'b0, 32'd0, 32'd0);
        finish_op(0, "bp");
        @(posedge clk); #1;
        chk("bp_no_stale_op", {31'd0, if0.busy}, 32'd0);

        // abort mid-compare, just before bit 10 is processed
        start_op(0, 32'h0000_1234, 32'h0000_4321, "abort");
        repeat (21) @(posedge clk);
        #1;
        chk("abort_pre_busy", {31'd0, if0.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ov", {31'd0, if0.out_valid}, 32'd0);
        chk("abort_Y", if0.Y, 32'd0);
        chk("abort_gt", {31'd0, if0.gt}, 32'd0);
        chk("abort_in_ready", {31'd0, if0.in_ready}, 32'd1);
        chk("abort_Y_dut1", if1.Y, 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle_ov", {31'd0, if0.out_valid}, 32'd0);
        run_op(0, 32'hFFFF_FFF9, 32'hFFFF_FFF8, 32, 32'hFFFF_FFF9, 1'b1, "m7_vs_m8");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/max_int32_serial.md
Name: max_int32_serial

Overview:
- Bit-serial 32-bit signed integer max with a valid/ready handshake on both sides.
- Mirrors the combinational min block: it selects the larger operand instead of the smaller, and resolves the comparison one bit per cycle, MSB first, in the style of the pimsynth bit-serial compute model.
- Sits in pimsynth benchmark datapaths as a sequential reduction primitive feeding max-pooling and argmax style kernels.

Parameters:
- WIDTH, 32, operand width in bits (must be >= 2).
- EARLY_EXIT, 0: 0 = always WIDTH compare cycles; 1 = finish on the first differing bit.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands A/B valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  signed operand A.
- B  input  WIDTH  signed operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Y  output  WIDTH  max(A,B), two's complement.
- gt  output  1  1 when A > B (signed).
- busy  output  1  high in CMP or DONE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; operand regs=0; gt=0; out_valid=0; Y=0; bit index=WIDTH-1; decided flag=0.
  - in_ready=1 once rst_n deasserts.
- FSM states: IDLE, CMP, DONE.
  - in_ready = (state==IDLE); busy = !in_ready; out_valid = (state==DONE).
- IDLE:
  - On in_valid && in_ready at edge 0: latch A, B.
  - Set idx=WIDTH-1, decided=0, gt=0, then go to CMP.
  - in_valid is ignored in all other states.
- CMP: the edge k (k=1..WIDTH) processes bit idx=WIDTH-k, then decrements idx.
  - At idx=WIDTH-1 (sign bit), if not yet decided and a[idx]!=b[idx]: gt=b[idx] (A is non-negative while B is negative); set decided.
  - At other bits, if not yet decided and a[idx]!=b[idx]: gt=a[idx]; set decided.
  - Once decided, gt is frozen.
  - EARLY_EXIT=0: go to DONE after the edge that processes bit 0 (edge WIDTH).
  - EARLY_EXIT=1: go to DONE after the edge that sets decided, or after bit 0 if the operands are equal.
- DONE:
  - Y = gt ? a_reg : b_reg. Tie (A==B) gives Y=B and gt=0.
  - Y and gt are held stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready: go to IDLE.
  - Y keeps its value until the next accept. Y is meaningful only while out_valid=1.
- Latency and throughput:
  - EARLY_EXIT=0: out_valid is visible exactly WIDTH cycles after the accepting edge.
  - EARLY_EXIT=1: latency is (WIDTH - index of MSB-most differing bit), range 1..WIDTH.
  - No overlap between operations: at most one operation per (latency + 2) cycles.
- Arithmetic: pure two's-complement compare, no overflow cases. WIDTH-bit datapath; idx counter is $clog2(WIDTH) bits and does not wrap.
- Reset mid-operation: any state aborts immediately to IDLE with the reset values above; the partial result is discarded and never presented.
- Simultaneous events: out_ready with out_valid=0 is ignored. Changes on A/B after the accept do not affect the result.

Test Plan:
- A=5, B=0xFFFFFFFD (-3), EARLY_EXIT=0 -> out_valid exactly 32 cycles after accept; Y=5, gt=1.
- A=0xFFFFFFFF (-1), B=0x80000000 (INT_MIN) -> Y=0xFFFFFFFF, gt=1. Swapped operands -> Y=0xFFFFFFFF, gt=0.
- A=B=0x12345678, EARLY_EXIT=1 -> latency 32, Y=0x12345678, gt=0 (tie selects B).
- EARLY_EXIT=1: A=0x7FFFFFFF, B=0x80000000 -> out_valid 1 cycle after accept, Y=0x7FFFFFFF, gt=1. A=0x00000010, B=0x00000018 -> latency 29 (first difference at bit 3), Y=0x18.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> Y, gt, out_valid stable, in_ready=0, new operands not accepted. out_ready=1 -> IDLE next edge, in_ready=1.
- Pulse rst_n low while CMP is at bit 10 -> out_valid=0, Y=0, gt=0, in_ready=1 immediately. The following transaction A=-7, B=-8 -> Y=0xFFFFFFF9, gt=1.
